c_modm_ud: RTL and testbench
============================

# c_modm_ud

Parametrised modulo-M up/down counter with synchronous load, count enable and a cascadable terminal-count output. It is the generic digit/stage counter for the clock datapath: seconds, minutes and hours stages are built by chaining instances, each stage's `ya` driving the next stage's `en`. It adds direction control, time-setting load, saturate mode and load-range error flagging.

## Interface

**Parameters**
- `WIDTH`, default 4: counter width in bits.
- `MODULO`, default 6: count range is 0 .. MODULO-1. Elaboration error unless 2 ≤ MODULO ≤ 2^WIDTH.
- `SATURATE`, default 0: 0 = wrap at terminal value; 1 = hold at terminal value.

**Ports**
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `en` in 1: count enable; one step per cycle while high.
- `up` in 1: direction; 1 = increment, 0 = decrement.
- `load` in 1: synchronous load of `load_val`.
- `load_val` in WIDTH: value to load.
- `salida` out WIDTH: current count, registered.
- `ya` out 1: terminal-count strobe, combinational; the cascade enable for the next stage.
- `err` out 1: sticky out-of-range load flag, registered.

## Operation

- Priority on each rising edge: `rst` > `load` > `en` > hold.
- `rst`: `salida` ← 0, `err` ← 0.
- `load`:
  - If `load_val` ≤ MODULO-1, `salida` ← `load_val`.
  - Otherwise `salida` ← MODULO-1 and `err` ← 1.
  - `err` stays set until `rst`.
- `en` with `up`=1:
  - `salida` < MODULO-1: increment.
  - `salida` = MODULO-1: go to 0 (SATURATE=0) or hold (SATURATE=1).
- `en` with `up`=0:
  - `salida` > 0: decrement.
  - `salida` = 0: go to MODULO-1 (SATURATE=0) or hold (SATURATE=1).
- Terminal value `tc`: `salida` = MODULO-1 when `up`=1; `salida` = 0 when `up`=0.
- `ya` = `en` & ~`load` & ~`rst` & `tc`. It is asserted in the same cycle as the step that wraps or holds, so a downstream stage steps on the same edge.
- Arithmetic uses WIDTH bits with no intermediate overflow. With MODULO = 2^WIDTH, the MODULO-1 comparison is all-ones.
- Changing `up` mid-count takes effect on the next enabled edge. No state depends on the previous direction.

## Timing

- Reset values: `salida` = 0, `err` = 0. `ya` is 0 while `rst` is high.
- Load latency: 1 cycle. `salida` shows `load_val` (or the clamped value) after the edge on which `load` is sampled.
- Count latency: 1 cycle per enabled edge. No pipelining.
- `ya` is combinational from `salida`, `en`, `up`, `load` and `rst`; it is valid before the edge it applies to.
- Simultaneous `load` and `en`: load wins and `ya` = 0. The chained stage therefore does not step during time-setting.
- `rst` asserted mid-count: the next edge yields 0 regardless of `en`/`load`. Counting resumes on the first enabled edge after `rst` falls.
- SATURATE=1 at the terminal with `en` held: `salida` stays constant and `ya` stays 1 every cycle.

## Structure

- Shared clock package holds the stage moduli, the common `WIDTH`, and the SATURATE encoding constants:
  - `MOD_SEG` = 60 (split 10/6 as digit pairs)
  - `MOD_HR24` = 24
  - `MOD_BCD` = 10
  - `MOD_SIX` = 6
- One natural sub-module: `c_modm_next`, the combinational next-state and terminal-detect function. Inputs: `salida`, `up`, SATURATE. Outputs: next value and `tc`.
- The top level holds only the priority mux, the `salida` register and the `err` register.
- Cascading wrappers (two-digit, HH:MM:SS) are separate blocks and out of scope here.

## Test plan

- **Reset and wrap-up.** MODULO=6, SATURATE=0: `rst` one cycle, then `en`=1, `up`=1 for 7 cycles. Required: `salida` = 0,1,2,3,4,5,0,1; `ya` = 1 only while `salida` = 5.
- **Wrap-down.** MODULO=6: load 2, then `en`=1, `up`=0 for 4 cycles. Required: `salida` = 2,1,0,5,4; `ya` = 1 only while `salida` = 0.
- **Saturate.** MODULO=10, SATURATE=1: load 8, then `en`=1, `up`=1 for 4 cycles. Required: `salida` = 8,9,9,9,9; `ya` = 1 on each cycle at 9.
- **Out-of-range load.** MODULO=6: `load_val`=13 with `load`=1. Required: `salida` = 5 and `err` = 1 next cycle. Then load 3: `err` stays 1. `rst`: `err` = 0 and `salida` = 0.
- **Load/enable priority.** `load`=1, `en`=1, `salida`=5, `up`=1. Required: `ya` = 0 that cycle and `salida` = `load_val` next cycle.
- **Two-stage cascade.** MODULO 10 then 6, first stage's `ya` driving the second's `en`, 60 enabled cycles from reset. Required: second stage steps once per 10 cycles and both read 0 after cycle 60.
- **Reset mid-count.** `rst` asserted mid-count. Required: 0 on the next edge.

Source files
------------

// File: rtl/c_modm_ud_pkg.sv
// Shared clock-datapath constants: stage moduli, common width and
// saturate-mode encodings used by every counter stage.
package c_modm_ud_pkg;

  // Common stage width, wide enough for the largest stage modulus (60).
  localparam int CLK_WIDTH = 6;

  // Stage moduli. Seconds/minutes (60) are normally built as BCD/six pairs.
  localparam int MOD_SEG  = 60;
  localparam int MOD_HR24 = 24;
  localparam int MOD_BCD  = 10;
  localparam int MOD_SIX  = 6;

  // SATURATE encodings.
  localparam int SAT_WRAP = 0;
  localparam int SAT_HOLD = 1;

  // True when a modulus is usable at a given width: 2 <= m <= 2^w.
  function automatic bit modulo_ok(input int w, input int m);
    return (m >= 2) && (longint'(m) <= (longint'(1) << w));
  endfunction

endpackage

// File: rtl/c_modm_next.sv
// Combinational next-count and terminal-detect for one modulo-M stage.
module c_modm_next
  import c_modm_ud_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULO   = 6,
  parameter int SATURATE = SAT_WRAP
) (
  input  logic [WIDTH-1:0] salida_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] nxt_o,
  output logic             tc_o
);

  // With MODULO = 2^WIDTH this is all-ones, so no wider arithmetic is needed.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO    = '0;
  localparam bit               HOLD    = (SATURATE == SAT_HOLD);

  // Step one position in the selected direction, wrapping or holding at the ends.
  always_comb begin
    nxt_o = salida_i;
    tc_o  = 1'b0;
    if (up_i) begin
      tc_o = (salida_i == MAX_VAL);
      if (!tc_o)     nxt_o = salida_i + ONE;
      else if (HOLD) nxt_o = salida_i;
      else           nxt_o = ZERO;
    end else begin
      tc_o = (salida_i == ZERO);
      if (!tc_o)     nxt_o = salida_i - ONE;
      else if (HOLD) nxt_o = salida_i;
      else           nxt_o = MAX_VAL;
    end
  end

endmodule

// File: rtl/c_modm_ud.sv
// Modulo-M up/down stage counter with load, enable, saturate option,
// sticky out-of-range load flag and combinational cascade strobe.
module c_modm_ud
  import c_modm_ud_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULO   = 6,
  parameter int SATURATE = SAT_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] salida,
  output logic             ya,
  output logic             err
);

  if (!modulo_ok(WIDTH, MODULO)) begin : g_bad_modulo
    $error("c_modm_ud: MODULO must satisfy 2 <= MODULO <= 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] salida_q, salida_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] step_val;
  logic             tc;

  c_modm_next #(
    .WIDTH    (WIDTH),
    .MODULO   (MODULO),
    .SATURATE (SATURATE)
  ) u_next (
    .salida_i (salida_q),
    .up_i     (up),
    .nxt_o    (step_val),
    .tc_o     (tc)
  );

  // Load beats count beats hold; out-of-range loads clamp and latch the error.
  always_comb begin
    salida_d = salida_q;
    err_d    = err_q;
    if (load) begin
      if (load_val <= MAX_VAL) begin
        salida_d = load_val;
      end else begin
        salida_d = MAX_VAL;
        err_d    = 1'b1;
      end
    end else if (en) begin
      salida_d = step_val;
    end
  end

  // State registers with synchronous reset taking top priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      salida_q <= '0;
      err_q    <= 1'b0;
    end else begin
      salida_q <= salida_d;
      err_q    <= err_d;
    end
  end

  // Cascade strobe is suppressed during load so the next stage stays put while setting time.
  assign ya     = en & ~load & ~rst & tc;
  assign salida = salida_q;
  assign err    = err_q;

endmodule

// File: tb/tb_c_modm_ud.sv
// Directed bench for c_modm_ud: wrap up/down, saturate, load clamping,
// priority, reset mid-count, full-range modulus and a two-stage cascade.
module tb_c_modm_ud;
  import c_modm_ud_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared control bus for the standalone instances.
  logic       rst = 1'b1, en = 1'b0, up = 1'b1, load = 1'b0;
  logic [3:0] load_val = '0;

  logic [3:0] salida6, salida10, salida16;
  logic       ya6, ya10, ya16, err6, err10, err16;

  // Cascade pair.
  logic       rst_c = 1'b1, en_c = 1'b0;
  logic [3:0] lv_c = '0;
  logic [3:0] sal_c10, sal_c6;
  logic       ya_c10, ya_c6, err_c10, err_c6;

  int tests_run    = 0;
  int tests_failed = 0;

  int exp_up[8]   = '{0, 1, 2, 3, 4, 5, 0, 1};
  int exp_down[5] = '{2, 1, 0, 5, 4};
  int exp_sat[5]  = '{8, 9, 9, 9, 9};

  c_modm_ud #(.WIDTH(4), .MODULO(MOD_SIX), .SATURATE(SAT_WRAP)) u6 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .salida(salida6), .ya(ya6), .err(err6));

  c_modm_ud #(.WIDTH(4), .MODULO(MOD_BCD), .SATURATE(SAT_HOLD)) u10s (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .salida(salida10), .ya(ya10), .err(err10));

  c_modm_ud #(.WIDTH(4), .MODULO(16), .SATURATE(SAT_WRAP)) u16 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .salida(salida16), .ya(ya16), .err(err16));

  c_modm_ud #(.WIDTH(4), .MODULO(MOD_BCD), .SATURATE(SAT_WRAP)) uc10 (
    .clk(clk), .rst(rst_c), .en(en_c), .up(1'b1), .load(1'b0), .load_val(lv_c),
    .salida(sal_c10), .ya(ya_c10), .err(err_c10));

  c_modm_ud #(.WIDTH(4), .MODULO(MOD_SIX), .SATURATE(SAT_WRAP)) uc6 (
    .clk(clk), .rst(rst_c), .en(ya_c10), .up(1'b1), .load(1'b0), .load_val(lv_c),
    .salida(sal_c6), .ya(ya_c6), .err(err_c6));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step();

    // Reset state
    rst = 1'b0;
    #1;
    check_eq("reset_salida", 32'(salida6), 0);
    check_eq("reset_err", 32'(err6), 0);

    // Wrap-up, MODULO 6
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check_eq("wrapup_salida", 32'(salida6), 32'(exp_up[i]));
      check_eq("wrapup_ya", 32'(ya6), (exp_up[i] == 5) ? 1 : 0);
      if (i < 7) step();
    end
    en = 1'b0;

    // Wrap-down from 2
    load = 1'b1; load_val = 4'd2;
    step();
    load = 1'b0; en = 1'b1; up = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("wrapdown_salida", 32'(salida6), 32'(exp_down[i]));
      check_eq("wrapdown_ya", 32'(ya6), (exp_down[i] == 0) ? 1 : 0);
      if (i < 4) step();
    end
    en = 1'b0;

    // Load beats enable at the terminal value
    load = 1'b1; load_val = 4'd5;
    step();
    load = 1'b0; en = 1'b1; up = 1'b1;
    #1;
    check_eq("prio_ya_noload", 32'(ya6), 1);
    load = 1'b1; load_val = 4'd3;
    #1;
    check_eq("prio_ya_load", 32'(ya6), 0);
    step();
    load = 1'b0; en = 1'b0;
    #1;
    check_eq("prio_salida", 32'(salida6), 3);

    // Out-of-range load clamps and sets sticky err
    load = 1'b1; load_val = 4'd13;
    step();
    load = 1'b0;
    #1;
    check_eq("oor_salida", 32'(salida6), 5);
    check_eq("oor_err", 32'(err6), 1);
    load = 1'b1; load_val = 4'd3;
    step();
    load = 1'b0;
    #1;
    check_eq("sticky_salida", 32'(salida6), 3);
    check_eq("sticky_err", 32'(err6), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check_eq("rst_clr_err", 32'(err6), 0);
    check_eq("rst_clr_salida", 32'(salida6), 0);

    // Reset mid-count wins over load and enable
    en = 1'b1; up = 1'b1;
    step();
    step();
    check_eq("mid_count", 32'(salida6), 2);
    rst = 1'b1; load = 1'b1; load_val = 4'd4;
    step();
    check_eq("mid_rst_salida", 32'(salida6), 0);
    load = 1'b0; up = 1'b0;
    #1;
    check_eq("ya_in_rst", 32'(ya6), 0);
    rst = 1'b0;
    #1;
    check_eq("ya_after_rst", 32'(ya6), 1);
    step();
    check_eq("resume_down", 32'(salida6), 5);
    en = 1'b0;

    // Saturate, MODULO 10
    load = 1'b1; load_val = 4'd8; up = 1'b1;
    step();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("sat_salida", 32'(salida10), 32'(exp_sat[i]));
      check_eq("sat_ya", 32'(ya10), (exp_sat[i] == 9) ? 1 : 0);
      if (i < 4) step();
    end
    check_eq("sat_err", 32'(err10), 0);
    en = 1'b0; load = 1'b1; load_val = 4'd0;
    step();
    load = 1'b0; en = 1'b1; up = 1'b0;
    #1;
    check_eq("sat_down_ya", 32'(ya10), 1);
    step();
    check_eq("sat_down_hold", 32'(salida10), 0);
    check_eq("sat_down_ya2", 32'(ya10), 1);
    en = 1'b0;

    // Full-range modulus 16: terminal is all-ones
    load = 1'b1; load_val = 4'd15;
    step();
    load = 1'b0; en = 1'b1; up = 1'b1;
    #1;
    check_eq("m16_load", 32'(salida16), 15);
    check_eq("m16_err", 32'(err16), 0);
    check_eq("m16_ya_up", 32'(ya16), 1);
    step();
    check_eq("m16_wrap_up", 32'(salida16), 0);
    up = 1'b0;
    #1;
    check_eq("m16_ya_down", 32'(ya16), 1);
    step();
    check_eq("m16_wrap_down", 32'(salida16), 15);
    en = 1'b0;

    // Two-stage cascade 10 -> 6 over 60 enabled cycles
    rst_c = 1'b1;
    step();
    rst_c = 1'b0; en_c = 1'b1;
    #1;
    check_eq("casc_start_lo", 32'(sal_c10), 0);
    check_eq("casc_start_hi", 32'(sal_c6), 0);
    for (int n = 1; n <= 60; n++) begin
      step();
      check_eq("casc_lo", 32'(sal_c10), 32'(n % 10));
      check_eq("casc_hi", 32'(sal_c6), 32'((n / 10) % 6));
      check_eq("casc_ya_hi", 32'(ya_c6), (n == 59) ? 1 : 0);
    end
    en_c = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
